// File: rtl/ts_packet_mux.sv
// rtl/ts_packet_mux.sv - four-channel MPEG-2 TS packet multiplexer with sync hunt and starvation abort
module ts_packet_mux #(
  parameter int         DATA_WIDTH = 8,
  parameter int         PKT_LEN    = 188,
  parameter logic [7:0] SYNC_BYTE  = 8'h47,
  parameter int         TIMEOUT    = 255
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic [DATA_WIDTH-1:0] rdata1,
  input  logic [DATA_WIDTH-1:0] rdata2,
  input  logic [DATA_WIDTH-1:0] rdata3,
  input  logic [DATA_WIDTH-1:0] rdata4,
  input  logic                  rempty1,
  input  logic                  rempty2,
  input  logic                  rempty3,
  input  logic                  rempty4,
  output logic                  ren1,
  output logic                  ren2,
  output logic                  ren3,
  output logic                  ren4,
  output logic [7:0]            out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_sop,
  output logic                  out_eop,
  output logic [1:0]            out_ch,
  output logic                  err_sync,
  output logic                  err_timeout,
  output logic [15:0]           drop_cnt
);

  localparam logic [0:0] HUNT = 1'b0;
  localparam logic [0:0] XFER = 1'b1;
  localparam logic [7:0] LAST_BYTE = 8'(PKT_LEN - 1);
  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  logic [0:0]            state;
  logic [1:0]            ptr;
  logic [1:0]            sel;
  logic [1:0]            cur;
  logic [7:0]            cnt;
  logic [7:0]            tcnt;
  logic [DATA_WIDTH-1:0] head;
  logic                  cur_empty;
  logic                  free;
  logic                  pop;
  logic                  is_sync;
  logic                  fwd;

  // Hunt walks the round-robin pointer; transfer stays on the locked channel.
  always_comb begin
    cur       = (state == XFER) ? sel : ptr;
    head      = rdata1;
    cur_empty = rempty1;
    case (cur)
      2'd0: begin head = rdata1; cur_empty = rempty1; end
      2'd1: begin head = rdata2; cur_empty = rempty2; end
      2'd2: begin head = rdata3; cur_empty = rempty3; end
      default: begin head = rdata4; cur_empty = rempty4; end
    endcase
  end

  assign free    = !out_valid || out_ready;
  assign pop     = free && !cur_empty;
  assign is_sync = (head == SYNC_BYTE);
  assign fwd     = pop && ((state == XFER) || is_sync);

  assign ren1 = pop && (cur == 2'd0);
  assign ren2 = pop && (cur == 2'd1);
  assign ren3 = pop && (cur == 2'd2);
  assign ren4 = pop && (cur == 2'd3);

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      state       <= HUNT;
      ptr         <= 2'd0;
      sel         <= 2'd0;
      cnt         <= 8'd0;
      tcnt        <= 8'd0;
      out_data    <= 8'd0;
      out_valid   <= 1'b0;
      out_sop     <= 1'b0;
      out_eop     <= 1'b0;
      out_ch      <= 2'd0;
      err_sync    <= 1'b0;
      err_timeout <= 1'b0;
      drop_cnt    <= 16'd0;
    end else begin
      err_sync    <= 1'b0;
      err_timeout <= 1'b0;
      // A discarded byte leaves the stage empty, just like an idle cycle.
      if (free) begin
        out_valid <= fwd;
        if (fwd) begin
          out_data <= 8'(head);
          out_ch   <= cur;
          out_sop  <= (state == HUNT);
          out_eop  <= (state == XFER) && (cnt == LAST_BYTE);
        end
      end
      case (state)
        HUNT: begin
          if (free) begin
            if (cur_empty) begin
              ptr <= ptr + 2'd1;
            end else if (is_sync) begin
              sel   <= ptr;
              cnt   <= 8'd1;
              tcnt  <= 8'd0;
              state <= XFER;
            end else begin
              err_sync <= 1'b1;
              if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
              ptr <= ptr + 2'd1;
            end
          end
        end
        XFER: begin
          // Backpressure freezes tcnt; only a free stage facing an empty FIFO counts as starvation.
          if (free) begin
            if (!cur_empty) begin
              cnt  <= cnt + 8'd1;
              tcnt <= 8'd0;
              if (cnt == LAST_BYTE) begin
                cnt   <= 8'd0;
                ptr   <= sel + 2'd1;
                state <= HUNT;
              end
            end else if (tcnt == LAST_WAIT) begin
              err_timeout <= 1'b1;
              tcnt        <= 8'd0;
              cnt         <= 8'd0;
              ptr         <= sel + 2'd1;
              state       <= HUNT;
            end else begin
              tcnt <= tcnt + 8'd1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ts_packet_mux.sv
// tb/tb_ts_packet_mux.sv - directed self-checking bench for ts_packet_mux
module tb_ts_packet_mux;

  logic        rclk = 1'b0;
  logic        rrst = 1'b1;
  logic [7:0]  rdata1, rdata2, rdata3, rdata4;
  logic        rempty1, rempty2, rempty3, rempty4;
  logic        ren1, ren2, ren3, ren4;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_sop, out_eop;
  logic [1:0]  out_ch;
  logic        err_sync, err_timeout;
  logic [15:0] drop_cnt;

  ts_packet_mux dut (
    .rclk(rclk), .rrst(rrst),
    .rdata1(rdata1), .rdata2(rdata2), .rdata3(rdata3), .rdata4(rdata4),
    .rempty1(rempty1), .rempty2(rempty2), .rempty3(rempty3), .rempty4(rempty4),
    .ren1(ren1), .ren2(ren2), .ren3(ren3), .ren4(ren4),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_sop(out_sop), .out_eop(out_eop), .out_ch(out_ch),
    .err_sync(err_sync), .err_timeout(err_timeout), .drop_cnt(drop_cnt)
  );

  always #5 rclk = ~rclk;

  logic [7:0]  fq [4][$];
  logic [11:0] exp_q [$];
  logic [11:0] log_q [$];
  int          stamp_q [$];
  logic [7:0]  rdata_v [4];
  logic [3:0]  rempty_v = 4'hF;
  logic [3:0]  pend = 4'h0;
  logic        rdy_plan = 1'b1;
  int          cyc = 0;
  int          ren_cnt [4];
  int          ren_total = 0;
  int          ren_multi = 0;
  int          ren_unfree = 0;
  int          es_cnt = 0;
  int          et_cnt = 0;
  int          t_to = 0;
  int          last_ren_cyc = 0;
  int          checks = 0;
  int          errors = 0;

  assign rdata1 = rdata_v[0];
  assign rdata2 = rdata_v[1];
  assign rdata3 = rdata_v[2];
  assign rdata4 = rdata_v[3];
  assign rempty1 = rempty_v[0];
  assign rempty2 = rempty_v[1];
  assign rempty3 = rempty_v[2];
  assign rempty4 = rempty_v[3];

  // FIFO model and output monitor: inputs change on the falling edge, DUT is sampled 1 ns later.
  always @(negedge rclk) begin
    logic [3:0] renv;
    for (int k = 0; k < 4; k++) begin
      if (pend[k] && fq[k].size() > 0) void'(fq[k].pop_front());
      rempty_v[k] = (fq[k].size() == 0);
      rdata_v[k]  = rempty_v[k] ? 8'h00 : fq[k][0];
    end
    pend = 4'h0;
    out_ready = rdy_plan;
    #1;
    cyc++;
    renv = {ren4, ren3, ren2, ren1};
    if (!rrst) begin
      pend = renv;
      for (int k = 0; k < 4; k++) begin
        if (renv[k]) begin
          ren_cnt[k]++;
          ren_total++;
          last_ren_cyc = cyc;
        end
      end
      if ($countones(renv) > 1) ren_multi++;
      if (renv != 4'h0 && out_valid && !out_ready) ren_unfree++;
      if (out_valid && out_ready) begin
        log_q.push_back({out_ch, out_sop, out_eop, out_data});
        stamp_q.push_back(cyc);
      end
      if (err_sync) es_cnt++;
      if (err_timeout) begin
        et_cnt++;
        t_to = cyc;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic add_pkt(input int ch, input logic [7:0] seed, input int len);
    logic [7:0] b;
    for (int j = 0; j < len; j++) begin
      b = (j == 0) ? 8'h47 : 8'(seed + 8'(j));
      fq[ch].push_back(b);
      exp_q.push_back({2'(ch), (j == 0), (j == 187), b});
    end
  endtask

  function automatic int count_bad();
    int bad = 0;
    if (log_q.size() != exp_q.size()) bad++;
    for (int i = 0; i < log_q.size() && i < exp_q.size(); i++)
      if (log_q[i] !== exp_q[i]) bad++;
    return bad;
  endfunction

  task automatic wait_beats(input string tag, input int n, input int budget);
    for (int i = 0; i < budget && log_q.size() < n; i++) @(posedge rclk);
    repeat (3) @(posedge rclk);
    check(tag, log_q.size(), n);
  endtask

  task automatic do_reset();
    @(posedge rclk); #2;
    rrst = 1'b1;
    @(negedge rclk); #3;
    for (int k = 0; k < 4; k++) begin
      fq[k].delete();
      ren_cnt[k] = 0;
    end
    exp_q.delete();
    log_q.delete();
    stamp_q.delete();
    es_cnt = 0;
    et_cnt = 0;
    rdy_plan = 1'b1;
    @(posedge rclk); #2;
    rrst = 1'b0;
  endtask

  initial begin
    logic [15:0] snap;
    int          rsnap, esnap, unstable;
    for (int k = 0; k < 4; k++) ren_cnt[k] = 0;
    #3;
    check("rst_outs", {out_valid, out_sop, out_eop, out_ch, out_data, err_sync, err_timeout}, 32'd0);
    check("rst_drop", drop_cnt, 32'd0);
    check("rst_ren", {ren4, ren3, ren2, ren1}, 32'd0);

    // Single packet on FIFO1
    do_reset();
    add_pkt(0, 8'h00, 188);
    wait_beats("t1_beats", 188, 400);
    check("t1_data", count_bad(), 0);
    check("t1_first", log_q[0], {2'd0, 1'b1, 1'b0, 8'h47});
    check("t1_last_eop", log_q[187][8], 1);
    check("t1_gapless", stamp_q[187] - stamp_q[0], 187);
    check("t1_ren1", ren_cnt[0], 188);

    // Four channels, round-robin, no bubbles
    do_reset();
    add_pkt(0, 8'h10, 188);
    add_pkt(1, 8'h20, 188);
    add_pkt(2, 8'h30, 188);
    add_pkt(3, 8'h40, 188);
    add_pkt(0, 8'h50, 188);
    wait_beats("t2_beats", 940, 1200);
    check("t2_data", count_bad(), 0);
    check("t2_gapless", stamp_q[939] - stamp_q[0], 939);
    check("t2_ch_last", log_q[752][11:10], 0);

    // Non-sync bytes ahead of a packet on FIFO2
    do_reset();
    fq[1].push_back(8'h00);
    fq[1].push_back(8'h12);
    add_pkt(1, 8'h60, 188);
    wait_beats("t3_beats", 188, 500);
    check("t3_data", count_bad(), 0);
    check("t3_err_sync", es_cnt, 2);
    check("t3_drop", drop_cnt, 2);

    // Starved packet on FIFO3 times out; hunt resumes at ch3
    do_reset();
    add_pkt(2, 8'h70, 100);
    for (int i = 0; i < 600 && et_cnt == 0; i++) @(posedge rclk);
    check("t4_et_cnt", et_cnt, 1);
    check("t4_to_delay", t_to - last_ren_cyc, 256);
    check("t4_ren3", ren_cnt[2], 100);
    @(posedge rclk); #2;
    add_pkt(3, 8'h80, 188);
    add_pkt(0, 8'h90, 188);
    wait_beats("t4_beats", 476, 800);
    check("t4_data", count_bad(), 0);
    check("t4_et_final", et_cnt, 1);

    // Backpressure for 20 cycles mid-packet
    do_reset();
    add_pkt(0, 8'hA0, 188);
    for (int i = 0; i < 200 && log_q.size() < 60; i++) @(posedge rclk);
    #2;
    rdy_plan = 1'b0;
    @(negedge rclk); #3;
    snap = {out_valid, out_sop, out_eop, out_ch, out_data, 3'b0};
    rsnap = ren_total;
    esnap = et_cnt;
    unstable = 0;
    for (int i = 0; i < 19; i++) begin
      @(negedge rclk); #3;
      if ({out_valid, out_sop, out_eop, out_ch, out_data, 3'b0} !== snap) unstable++;
    end
    check("t5_valid_held", snap[15], 1);
    check("t5_stable", unstable, 0);
    check("t5_no_ren", ren_total - rsnap, 0);
    check("t5_no_timeout", et_cnt - esnap, 0);
    @(posedge rclk); #2;
    rdy_plan = 1'b1;
    wait_beats("t5_beats", 188, 400);
    check("t5_data", count_bad(), 0);

    // Reset mid-packet, then a fresh packet on FIFO3
    do_reset();
    add_pkt(0, 8'hB0, 188);
    for (int i = 0; i < 200 && log_q.size() < 50; i++) @(posedge rclk);
    #2;
    rrst = 1'b1;
    #1;
    check("t6_rst_outs", {out_valid, out_sop, out_eop, out_ch, out_data, err_sync, err_timeout}, 32'd0);
    check("t6_rst_drop", drop_cnt, 32'd0);
    do_reset();
    add_pkt(2, 8'hC0, 188);
    wait_beats("t6_beats", 188, 400);
    check("t6_data", count_bad(), 0);

    check("ren_multi", ren_multi, 0);
    check("ren_unfree", ren_unfree, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
